// File: rtl/restoring_div_ctrl.sv
// Iterative restoring divider: one time-shared WIDTH+1 subtractor row, one quotient bit per cycle.
// Optional abort input is enabled by defining RDIV_ABORT_EN.
module restoring_div_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef RDIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH:0]   pr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   dx;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] borrow;
    logic [WIDTH:0]   row_out;
    logic             sel;
    logic [WIDTH-1:0] q_shift;

    logic             abort_req;
    logic             load_op;
    logic             step;
    logic             load_res;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             res_z;

    // PR never exceeds D after a restore, so its MSB only matters inside the row
    logic             unused_pr_msb;
    assign unused_pr_msb = pr[WIDTH];

`ifdef RDIV_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign busy = (state == ITER);
    assign done = (state == DONE);

    // Subtractor row: ripple borrow, MSB borrow-out selects restore for every cell
    always_comb begin
        t         = {pr[WIDTH-1:0], q[WIDTH-1]};
        dx        = {1'b0, d};
        diff      = '0;
        borrow    = '0;
        for (int unsigned i = 0; i <= WIDTH; i++) begin
            diff[i]     = t[i] ^ dx[i] ^ borrow[i];
            borrow[i+1] = (~t[i] & dx[i]) | (~(t[i] ^ dx[i]) & borrow[i]);
        end
        sel       = borrow[WIDTH+1];
        row_out   = sel ? t : diff;
        q_shift   = {q[WIDTH-2:0], ~sel};
    end

    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        step       = 1'b0;
        load_res   = 1'b0;
        res_q      = q_shift;
        res_r      = row_out[WIDTH-1:0];
        res_z      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        load_op    = 1'b1;
                        state_next = ITER;
                    end else begin
                        load_res   = 1'b1;
                        res_q      = '1;
                        res_r      = dividend;
                        res_z      = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            ITER: begin
                if (abort_req) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == '0) begin
                        load_res   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pr          <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (load_op) begin
                pr    <= '0;
                q     <= dividend;
                d     <= divisor;
                count <= CW'(WIDTH - 1);
            end
            if (step) begin
                pr <= row_out;
                q  <= q_shift;
                if (count != '0) begin
                    count <= count - 1'b1;
                end
            end
            if (load_res) begin
                quotient    <= res_q;
                remainder   <= res_r;
                div_by_zero <= res_z;
            end
        end
    end

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Self-checking bench for restoring_div_ctrl: directed cases plus randomized operands
// against a plain-arithmetic division model; abort cases when RDIV_ABORT_EN is defined.
module tb_restoring_div_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;
    logic         prev_z;

    restoring_div_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef RDIV_ABORT_EN
        .abort       (abort),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] eq, output logic [W-1:0] er,
                                    output logic ez);
        if (b == 0) begin
            eq = '1;
            er = a;
            ez = 1'b1;
        end else begin
            eq = a / b;
            er = a % b;
            ez = 1'b0;
        end
    endfunction

    // chained: operands/start already presented by the previous op's keep
    // keep: leave start high and present na/nb in the done cycle
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise,
                          input bit chained, input bit keep,
                          input logic [W-1:0] na, input logic [W-1:0] nb);
        logic [W-1:0] eq, er;
        logic         ez;
        int           cyc, bcnt;
        ref_div(a, b, eq, er, ez);
        if (!chained) begin
            @(negedge clk);
            start    = 1'b1;
            dividend = a;
            divisor  = b;
        end
        @(negedge clk);
        if (!keep) start = 1'b0;
        cyc  = 1;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            check("hold_prev", 32'({quotient, remainder, div_by_zero}),
                  32'({prev_q, prev_r, prev_z}));
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        check("done_latency", 32'(cyc), (b == 0) ? 32'd1 : 32'(W + 1));
        check("busy_cycles", 32'(bcnt), (b == 0) ? 32'd0 : 32'(W));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_by_zero", 32'(div_by_zero), 32'(ez));
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
        if (keep) begin
            dividend = na;
            divisor  = nb;
        end else begin
            start = 1'b0;
        end
        @(negedge clk);
        check("done_single_pulse", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        prev_z   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({busy, done, quotient, remainder, div_by_zero}), 32'd0);
        rst_n = 1'b1;

        run_op(8'd100, 8'd7, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        run_op(8'd255, 8'd1, 1'b0, 1'b0, 1'b1, 8'd5, 8'd9);
        run_op(8'd5, 8'd9, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        run_op(8'd13, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        run_op(8'd200, 8'd200, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        run_op(8'd173, 8'd11, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

        // synchronous reset during iteration 4 of 100/7
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", 32'({busy, done, quotient, remainder, div_by_zero}), 32'd0);
        rst_n  = 1'b1;
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
        for (int i = 0; i < int'(W) + 2; i++) begin
            @(negedge clk);
            check("no_done_after_reset", 32'({done, busy}), 32'd0);
        end
        run_op(8'd50, 8'd6, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

`ifdef RDIV_ABORT_EN
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_results", 32'({quotient, remainder, div_by_zero}),
              32'({prev_q, prev_r, prev_z}));
        for (int i = 0; i < int'(W) + 2; i++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'({done, busy}), 32'd0);
        end
        run_op(8'd77, 8'd5, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 255));
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'd0, 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/restoring_div_ctrl.md
# restoring_div_ctrl

Iterative controller for the restoring-divider datapath. It accepts one unsigned dividend/divisor pair per start and drives a single row of WIDTH+1 subtractor cells for WIDTH iterations, one quotient bit per cycle. The borrow-out of the row's MSB drives the cells' restore-select. The block sits between the divider's command interface and the subtractor-cell row, and replaces the fully unrolled array with one time-shared row.

## Interface
- WIDTH, 8, operand width in bits; minimum 2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- dividend  in  WIDTH  unsigned dividend; captured at the accepting edge.
- divisor  in  WIDTH  unsigned divisor; captured at the accepting edge.
- busy  out  1  high in ITER.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- quotient  out  WIDTH  result; holds until the next done.
- remainder  out  WIDTH  result; holds until the next done.
- div_by_zero  out  1  flag for the last completed operation; updated with done.
- abort  in  1  present only with RDIV_ABORT_EN.

## Operation
- States: IDLE, ITER, DONE.
- IDLE, start=1, divisor≠0:
  - Load partial remainder PR (WIDTH+1 bits) = 0, Q = dividend, D = {1'b0, divisor}, and count = WIDTH-1.
  - Go to ITER.
- IDLE, start=1, divisor=0:
  - Go directly to DONE.
  - At that edge, quotient becomes all-ones, remainder becomes dividend, and div_by_zero becomes 1.
- ITER, once per cycle:
  - Shift T = {PR[WIDTH-1:0], Q[WIDTH-1]}.
  - Row computes T − D with a ripple borrow. Cell i: a=T[i], b=D[i], b_in=borrow[i-1]; b_in of cell 0 is 0.
  - sel is the MSB borrow-out for all cells. A cell's out is T[i] when sel=1 (restore) and the difference bit when sel=0.
  - Register PR ← row out, and Q ← {Q[WIDTH-2:0], ~sel}.
  - When count=0, go to DONE. Otherwise decrement count.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - On entry, quotient ← Q, remainder ← PR[WIDTH-1:0], div_by_zero ← 0. Exception: the divide-by-zero path sets div_by_zero ← 1.
- start is ignored outside IDLE. It is not queued.
- Output registers quotient, remainder and div_by_zero change only on the edge entering DONE. They hold the previous result while busy.
- Arithmetic:
  - All values are unsigned.
  - PR is WIDTH+1 bits, so the intermediate shift never overflows.
  - Remainder is always less than divisor.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE; busy, done, div_by_zero, quotient, remainder, count, PR and Q all become 0.
- Reset mid-operation aborts silently: no done, outputs cleared.
- Accept edge E0. ITER occupies the cycles between E0 and E_WIDTH, and busy=1 during those WIDTH cycles.
- DONE is entered at E_WIDTH. done=1 in the cycle after E_WIDTH, and state is IDLE again at E_WIDTH+1.
- Divide-by-zero: done=1 in the cycle immediately after E0, and busy never rises.
- A new start is accepted at the earliest in the cycle after done. Back-to-back throughput is one operation per WIDTH+2 cycles.
- start held high continuously retriggers on every return to IDLE.

## Configuration
- RDIV_ABORT_EN defined:
  - abort port exists.
  - abort=1 in ITER returns to IDLE at the next edge, with busy=0 and no done.
  - quotient, remainder and div_by_zero keep their previous values.
  - abort is ignored in IDLE and DONE.
  - If abort and reset coincide, reset wins.
- RDIV_ABORT_EN undefined: no abort port, and every accepted operation runs to done.

## Test plan
- WIDTH=8, 100/7: done in the 9th cycle after the accept edge (one cycle after E8), quotient=14, remainder=2, div_by_zero=0; busy high for exactly 8 cycles.
- 255/1 then 5/9 back-to-back, with start held high: results (255,0) and then (0,5); second accept in the IDLE cycle after the first done; each done is a single-cycle pulse.
- 13/0: done in the cycle after accept, quotient=0xFF, remainder=13, div_by_zero=1, busy never high. A following 200/200 gives (1,0) and clears div_by_zero.
- start pulses during ITER with different operands: ignored, the original result is returned, and the old outputs stay stable until done.
- rst_n=0 at iteration 4 of 100/7: next cycle all outputs are 0 and state is IDLE; a following 50/6 gives (8,2).
- With RDIV_ABORT_EN, abort at iteration 3: busy=0 the next cycle, no done, and the prior results are unchanged.
